// File: rtl/pattern_generator_pkg.sv
// pattern_generator_pkg: binary32 field widths, op/rounding encodings and special constants
package pattern_generator_pkg;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int BIAS = 127;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;
    localparam logic [30:0] INF = 31'h7F80_0000;
    localparam logic [30:0] MAXF = 31'h7F7F_FFFF;
    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_e;
    typedef enum logic [1:0] {RNE, RTZ, RUP, RDN} rnd_e;
    typedef enum logic {IDLE, BUSY} state_e;
endpackage

// File: rtl/fp_round_pack.sv
// fp_round_pack: rounds a normalised significand+GRS and packs binary32 with overflow/underflow flags
module fp_round_pack
    import pattern_generator_pkg::*;
(
    input  logic              sign,
    input  logic signed [9:0] exp_u,
    input  logic [26:0]       sig,
    input  logic [1:0]        mode,
    output logic [31:0]       y,
    output logic              ovf,
    output logic              unf
);
    logic inexact, inc, to_zero;
    logic [MAN_W+1:0] rnd;
    logic [MAN_W-1:0] man;
    logic signed [9:0] bexp;
    always_comb begin
        inexact = |sig[2:0];
        inc = (mode == RNE) ? sig[2] & (sig[3] | sig[1] | sig[0]) :
              (mode == RUP) ? inexact & ~sign :
              (mode == RDN) ? inexact & sign : 1'b0;
        rnd = {1'b0, sig[26:3]} + {{(MAN_W+1){1'b0}}, inc};
        man = rnd[MAN_W+1] ? rnd[MAN_W:1] : rnd[MAN_W-1:0];
        bexp = exp_u + 10'(BIAS) + (rnd[MAN_W+1] ? 10'sd1 : 10'sd0);
        to_zero = (mode == RTZ) | ((mode == RUP) & sign) | ((mode == RDN) & ~sign);
        ovf = bexp > 10'sd254;
        unf = bexp < 10'sd1;
        y = ovf ? {sign, to_zero ? MAXF : INF} : {sign, bexp[EXP_W-1:0], man};
    end
endmodule

// File: rtl/pattern_generator.sv
// pattern_generator: binary32 add/sub/mul/div golden model with start/busy handshake and held outputs
module pattern_generator
    import pattern_generator_pkg::*;
#(
    parameter int LATENCY = 2
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [1:0]  Sel,
    input  logic [1:0]  round,
    input  logic        start,
    input  logic        genonly,
    input  logic        FIN,
    output logic [31:0] Y,
    output logic        Overflow,
    output logic        Error
);
    state_e state;
    logic [7:0] cnt;
    logic [31:0] a_r, b_r, rp_y, y_n;
    logic [1:0] sel_r, rnd_r;
    logic [EXP_W-1:0] ea, eb, ex, ey, d;
    logic [MAN_W:0] ma, mb, mx, my, rem;
    logic sa, sb, sbe, sx, sy, sm, za, zb, ia, ib, na, nb, is_add, swap, r_sign;
    logic rp_ovf, rp_unf, ovf_n, err_n;
    logic signed [9:0] eau, ebu, exu, add_e, mul_e, div_e, r_e;
    logic [27:0] xw, yw, yal, sum, q;
    logic [55:0] wide;
    logic [47:0] p;
    logic [50:0] num, den;
    logic [4:0] lz;
    logic [26:0] add_s, mul_s, div_s, r_s;
    always_comb begin
        sa = a_r[31];
        sb = b_r[31];
        ea = a_r[30:23];
        eb = b_r[30:23];
        za = ea == '0;
        zb = eb == '0;
        ia = (&ea) & ~(|a_r[22:0]);
        ib = (&eb) & ~(|b_r[22:0]);
        na = (&ea) & (|a_r[22:0]);
        nb = (&eb) & (|b_r[22:0]);
        ma = za ? '0 : {1'b1, a_r[22:0]};
        mb = zb ? '0 : {1'b1, b_r[22:0]};
        eau = $signed({2'b0, ea}) - 10'(BIAS);
        ebu = $signed({2'b0, eb}) - 10'(BIAS);
        is_add = ~sel_r[1];
        sbe = sb ^ (sel_r == OP_SUB);
        // larger magnitude goes first so the aligned difference is never negative
        swap = {eb, mb} > {ea, ma};
        ex = swap ? eb : ea;
        ey = swap ? ea : eb;
        mx = swap ? mb : ma;
        my = swap ? ma : mb;
        sx = swap ? sbe : sa;
        sy = swap ? sa : sbe;
        exu = swap ? ebu : eau;
        d = ex - ey;
        xw = {1'b0, mx, 3'b0};
        yw = {1'b0, my, 3'b0};
        wide = {yw, 28'b0} >> (d > 8'd31 ? 8'd31 : d);
        yal = {wide[55:29], wide[28] | (|wide[27:0])};
        sum = (sx ^ sy) ? xw - yal : xw + yal;
        lz = '0;
        for (int i = 0; i < 27; i++) if (sum[i]) lz = 5'(26 - i);
        add_s = sum[27] ? {sum[27:2], |sum[1:0]} : sum[26:0] << lz;
        add_e = sum[27] ? exu + 10'sd1 : exu - $signed({5'b0, lz});
        sm = sa ^ sb;
        p = ma * mb;
        mul_s = p[47] ? {p[47:22], |p[21:0]} : {p[46:21], |p[20:0]};
        mul_e = eau + ebu + (p[47] ? 10'sd1 : 10'sd0);
        num = {ma, 27'b0};
        den = {27'b0, zb ? 24'd1 : mb};
        q = 28'(num / den);
        rem = 24'(num % den);
        div_s = q[27] ? {q[27:2], (|q[1:0]) | (|rem)} : {q[26:1], q[0] | (|rem)};
        div_e = eau - ebu - (q[27] ? 10'sd0 : 10'sd1);
        r_sign = is_add ? sx : sm;
        r_e = is_add ? add_e : sel_r[0] ? div_e : mul_e;
        r_s = is_add ? add_s : sel_r[0] ? div_s : mul_s;
    end
    fp_round_pack u_rp (
        .sign  (r_sign),
        .exp_u (r_e),
        .sig   (r_s),
        .mode  (rnd_r),
        .y     (rp_y),
        .ovf   (rp_ovf),
        .unf   (rp_unf)
    );
    always_comb begin
        err_n = 1'b0;
        ovf_n = 1'b0;
        y_n = rp_unf ? {r_sign, 31'b0} : rp_y;
        if (na | nb) begin
            err_n = 1'b1;
            y_n = QNAN;
        end else if (is_add) begin
            if (ia & ib & (sa ^ sbe)) begin
                err_n = 1'b1;
                y_n = QNAN;
            end else if (ia | ib) y_n = {ia ? sa : sbe, INF};
            else if (sum == '0) y_n = {rnd_r == RDN, 31'b0};
            else ovf_n = rp_ovf;
        end else if (~sel_r[0]) begin
            if ((ia | ib) & (za | zb)) begin
                err_n = 1'b1;
                y_n = QNAN;
            end else if (ia | ib) y_n = {sm, INF};
            else if (za | zb) y_n = {sm, 31'b0};
            else ovf_n = rp_ovf;
        end else begin
            if ((za & zb) | (ia & ib)) begin
                err_n = 1'b1;
                y_n = QNAN;
            end else if (ia) y_n = {sm, INF};
            else if (zb) begin
                err_n = 1'b1;
                y_n = {sm, INF};
            end else if (ib | za) y_n = {sm, 31'b0};
            else ovf_n = rp_ovf;
        end
    end
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
            cnt <= '0;
            a_r <= '0;
            b_r <= '0;
            sel_r <= '0;
            rnd_r <= '0;
            Y <= '0;
            Overflow <= 1'b0;
            Error <= 1'b0;
        end else if (state == IDLE) begin
            if (start & ~FIN) begin
                state <= BUSY;
                cnt <= '0;
                a_r <= A;
                b_r <= B;
                sel_r <= Sel;
                rnd_r <= round;
            end
        end else if (cnt == 8'(LATENCY - 2)) begin
            state <= IDLE;
            if (genonly) begin
                Y <= y_n;
                Overflow <= ovf_n;
                Error <= err_n;
            end
        end else cnt <= cnt + 8'd1;
    end
endmodule

// File: tb/tb_pattern_generator.sv
// tb_pattern_generator: directed vector table plus control-sequence checks for pattern_generator
module tb_pattern_generator;
    logic Clock = 1'b0;
    logic Reset, start, genonly, FIN, Error, Overflow;
    logic [31:0] A, B, Y;
    logic [1:0] Sel, round;
    int checks = 0;
    int errors = 0;
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  sel;
        logic [1:0]  rnd;
        logic [31:0] y;
        logic        ovf;
        logic        err;
    } vec_t;
    localparam int N = 30;
    vec_t vt [N];

    pattern_generator dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .A        (A),
        .B        (B),
        .Sel      (Sel),
        .round    (round),
        .start    (start),
        .genonly  (genonly),
        .FIN      (FIN),
        .Y        (Y),
        .Overflow (Overflow),
        .Error    (Error)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string name, input logic [31:0] ey, input logic eo, input logic ee);
        checks++;
        if (Y !== ey || Overflow !== eo || Error !== ee) begin
            errors++;
            $display("FAIL %s: got Y=%h ovf=%b err=%b expected Y=%h ovf=%b err=%b",
                     name, Y, Overflow, Error, ey, eo, ee);
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] s, input logic [1:0] r);
        @(negedge Clock);
        A = a;
        B = b;
        Sel = s;
        round = r;
        start = 1'b1;
        @(negedge Clock);
        start = 1'b0;
        @(negedge Clock);
    endtask

    initial begin
        vt[0]  = '{32'h43700000, 32'h42F00000, 2'b00, 2'b00, 32'h43B40000, 1'b0, 1'b0};
        vt[1]  = '{32'h43700000, 32'h42F00000, 2'b01, 2'b00, 32'h42F00000, 1'b0, 1'b0};
        vt[2]  = '{32'hC3700000, 32'hC2F00000, 2'b10, 2'b00, 32'h46E10000, 1'b0, 1'b0};
        vt[3]  = '{32'h43700000, 32'hC2F00000, 2'b11, 2'b00, 32'hC0000000, 1'b0, 1'b0};
        vt[4]  = '{32'h40008000, 32'h40808000, 2'b00, 2'b00, 32'h40C0C000, 1'b0, 1'b0};
        vt[5]  = '{32'h40008000, 32'h40808000, 2'b00, 2'b01, 32'h40C0C000, 1'b0, 1'b0};
        vt[6]  = '{32'h40008000, 32'h40808000, 2'b00, 2'b10, 32'h40C0C000, 1'b0, 1'b0};
        vt[7]  = '{32'h40008000, 32'h40808000, 2'b00, 2'b11, 32'h40C0C000, 1'b0, 1'b0};
        vt[8]  = '{32'h7F010000, 32'h7F010000, 2'b00, 2'b00, 32'h7F800000, 1'b1, 1'b0};
        vt[9]  = '{32'h7F010000, 32'h7F010000, 2'b00, 2'b01, 32'h7F7FFFFF, 1'b1, 1'b0};
        vt[10] = '{32'h7F800000, 32'hFF800000, 2'b00, 2'b00, 32'h7FC00000, 1'b0, 1'b1};
        vt[11] = '{32'h00000000, 32'h00000000, 2'b11, 2'b00, 32'h7FC00000, 1'b0, 1'b1};
        vt[12] = '{32'h7F010000, 32'h7F010000, 2'b01, 2'b00, 32'h00000000, 1'b0, 1'b0};
        vt[13] = '{32'h00010000, 32'hFF010000, 2'b11, 2'b00, 32'h80000000, 1'b0, 1'b0};
        vt[14] = '{32'h3F800000, 32'h33800000, 2'b00, 2'b00, 32'h3F800000, 1'b0, 1'b0};
        vt[15] = '{32'h3F800000, 32'h33800000, 2'b00, 2'b10, 32'h3F800001, 1'b0, 1'b0};
        vt[16] = '{32'h3F800000, 32'h33800000, 2'b01, 2'b00, 32'h3F7FFFFF, 1'b0, 1'b0};
        vt[17] = '{32'h3F800000, 32'h40400000, 2'b11, 2'b00, 32'h3EAAAAAB, 1'b0, 1'b0};
        vt[18] = '{32'h3F800000, 32'h40400000, 2'b11, 2'b01, 32'h3EAAAAAA, 1'b0, 1'b0};
        vt[19] = '{32'h7F000000, 32'h40000000, 2'b10, 2'b10, 32'h7F800000, 1'b1, 1'b0};
        vt[20] = '{32'h7F000000, 32'hC0000000, 2'b10, 2'b10, 32'hFF7FFFFF, 1'b1, 1'b0};
        vt[21] = '{32'h7F000000, 32'h40000000, 2'b10, 2'b11, 32'h7F7FFFFF, 1'b1, 1'b0};
        vt[22] = '{32'h00800000, 32'h3F000000, 2'b10, 2'b00, 32'h00000000, 1'b0, 1'b0};
        vt[23] = '{32'h3F800000, 32'h00000000, 2'b11, 2'b00, 32'h7F800000, 1'b0, 1'b1};
        vt[24] = '{32'hBF800000, 32'h00000000, 2'b11, 2'b00, 32'hFF800000, 1'b0, 1'b1};
        vt[25] = '{32'h7F800000, 32'h40000000, 2'b10, 2'b00, 32'h7F800000, 1'b0, 1'b0};
        vt[26] = '{32'h00000000, 32'h7F800000, 2'b10, 2'b00, 32'h7FC00000, 1'b0, 1'b1};
        vt[27] = '{32'h7FC00001, 32'h3F800000, 2'b00, 2'b00, 32'h7FC00000, 1'b0, 1'b1};
        vt[28] = '{32'h7F010000, 32'h7F010000, 2'b01, 2'b11, 32'h80000000, 1'b0, 1'b0};
        vt[29] = '{32'h7F800000, 32'h7F800000, 2'b11, 2'b00, 32'h7FC00000, 1'b0, 1'b1};
        Reset = 1'b0;
        start = 1'b0;
        genonly = 1'b1;
        FIN = 1'b0;
        A = '0;
        B = '0;
        Sel = '0;
        round = '0;
        repeat (2) @(negedge Clock);
        chk("reset_state", 32'h0, 1'b0, 1'b0);
        Reset = 1'b1;
        for (int i = 0; i < N; i++) begin
            issue(vt[i].a, vt[i].b, vt[i].sel, vt[i].rnd);
            chk($sformatf("vec%0d", i), vt[i].y, vt[i].ovf, vt[i].err);
        end
        issue(32'h43700000, 32'h42F00000, 2'b00, 2'b00);
        chk("pre_reset", 32'h43B40000, 1'b0, 1'b0);
        @(negedge Clock);
        A = 32'hC3700000;
        B = 32'hC2F00000;
        Sel = 2'b10;
        start = 1'b1;
        @(posedge Clock);
        #2 Reset = 1'b0;
        start = 1'b0;
        #1 chk("reset_async", 32'h0, 1'b0, 1'b0);
        @(negedge Clock);
        Reset = 1'b1;
        repeat (3) @(negedge Clock);
        chk("reset_abort", 32'h0, 1'b0, 1'b0);
        issue(32'h43700000, 32'h42F00000, 2'b00, 2'b00);
        chk("pre_fin", 32'h43B40000, 1'b0, 1'b0);
        FIN = 1'b1;
        issue(32'h43700000, 32'hC2F00000, 2'b11, 2'b00);
        chk("fin_blocks", 32'h43B40000, 1'b0, 1'b0);
        FIN = 1'b0;
        @(negedge Clock);
        A = 32'h43700000;
        B = 32'h42F00000;
        Sel = 2'b01;
        round = 2'b00;
        start = 1'b1;
        @(negedge Clock);
        start = 1'b0;
        FIN = 1'b1;
        @(negedge Clock);
        chk("fin_in_busy", 32'h42F00000, 1'b0, 1'b0);
        FIN = 1'b0;
        genonly = 1'b0;
        issue(32'hC3700000, 32'hC2F00000, 2'b10, 2'b00);
        chk("genonly_hold", 32'h42F00000, 1'b0, 1'b0);
        issue(32'h7F010000, 32'h7F010000, 2'b00, 2'b00);
        chk("genonly_hold_ovf", 32'h42F00000, 1'b0, 1'b0);
        genonly = 1'b1;
        @(negedge Clock);
        A = 32'h43700000;
        B = 32'hC2F00000;
        Sel = 2'b11;
        start = 1'b1;
        @(negedge Clock);
        A = 32'h43700000;
        B = 32'h42F00000;
        Sel = 2'b00;
        @(negedge Clock);
        start = 1'b0;
        chk("busy_ignores_start", 32'hC0000000, 1'b0, 1'b0);
        repeat (2) @(negedge Clock);
        chk("no_late_capture", 32'hC0000000, 1'b0, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pattern_generator.md
Name: pattern_generator

Overview:
- Single-precision (IEEE-754 binary32) arithmetic unit that acts as a pattern generator and golden model for FPU verification.
- On a `start` pulse it captures operands A, B, the operation select and the rounding mode, computes add/sub/mul/div, and drives the result Y with the Overflow and Error flags.
- Sits beside or in place of the FPU datapath in the test environment.
- `genonly` and `FIN` control output enabling and end-of-run freeze.

Parameters:
- LATENCY, 2, clock edges from the capture edge to the output update (fixed; minimum 2).

Ports:
- Clock  in  1  rising-edge clock
- Reset  in  1  asynchronous active-low reset
- A  in  32  operand A, binary32
- B  in  32  operand B, binary32
- Sel  in  2  operation: 00 add, 01 sub (A-B), 10 mul, 11 div (A/B)
- round  in  2  rounding mode: 00 nearest-even, 01 toward zero, 10 toward +inf, 11 toward -inf
- start  in  1  one-cycle request; operands sampled at the same edge
- Error  out  1  invalid operation or NaN result
- Overflow  out  1  result exponent exceeded 254
- Y  out  32  result, binary32
- genonly  in  1  1 = outputs updated from computed result; 0 = outputs held
- FIN  in  1  end of run; 1 = block ignores start and freezes outputs

Behaviour:
- Reset (Reset=0, asynchronous): Y=0, Overflow=0, Error=0, state IDLE, capture registers cleared.
- States:
  - IDLE: a rising edge with start=1 and FIN=0 captures A, B, Sel, round and moves to BUSY.
  - BUSY: lasts LATENCY-1 cycles. On exit, Y, Overflow and Error are written together (only if genonly=1), then the state returns to IDLE.
- start during BUSY is ignored.
- Outputs hold their value until the next completion or reset.
- Reset asserted mid-BUSY aborts the operation; outputs go to reset values.
- FIN=1 in IDLE blocks new captures. FIN=1 in BUSY lets the current operation complete.
- Arithmetic:
  - Exponent 0 inputs (zero/denormal) are treated as signed zero (flush-to-zero).
  - Results below the minimum normal flush to signed zero; Overflow=0 in that case.
  - Mantissa datapath uses 24-bit significand plus guard/round/sticky; normalise before rounding.
  - Re-normalise if rounding carries out.
  - Sub is add with B's sign inverted.
  - Exact zero from add/sub is +0 for modes 00/01/10 and -0 for mode 11.
  - Mul: exponent sum minus 127. Div: exponent difference plus 127, 26+ quotient bits with sticky.
- Special cases:
  - Any NaN input, inf-inf (effective), 0*inf, 0/0 or inf/inf: Error=1, Y=0x7FC00000, Overflow=0.
  - Finite nonzero divided by zero: Error=1, Y=±inf (sign XOR).
  - Infinity operand with a valid operation: Y=±inf, flags 0.
  - Overflow: Overflow=1. Y is ±inf, except max finite 0x7F7FFFFF/0xFF7FFFFF when the mode rounds toward zero for that sign (01 always; 10 for negative results; 11 for positive results).
- Error and Overflow are never both 1.

Decomposition:
- Shared package: float field widths (EXP_W=8, MAN_W=23), BIAS=127, op-select and rounding-mode enums, QNAN/INF/MAXF constants.
- One sub-module: fp_round_pack, which takes sign, unbiased exponent, significand+GRS and mode, and returns packed Y plus the overflow/underflow indication.

Test Plan:
- Basic ops, A=0x43700000 (240), B=0x42F00000 (120), round 00:
  - add -> Y=0x43B40000.
  - sub -> Y=0x42F00000.
- Sign handling, round 00:
  - mul with A=0xC3700000, B=0xC2F00000 -> Y=0x46E10000.
  - div with A=0x43700000, B=0xC2F00000 -> Y=0xC0000000. All flags 0.
- Rounding modes: A=0x40008000, B=0x40808000, add, each round 00..11 -> Y=0x40C0C000 (exact), flags 0.
- Overflow: A=B=0x7F010000 add, round 00 -> Overflow=1, Y=0x7F800000. Same with round 01 -> Y=0x7F7FFFFF.
- Invalid and zero cases:
  - 0x7F800000 + 0xFF800000 -> Error=1, Y=0x7FC00000.
  - 0/0 div -> Error=1.
  - A=0x7F010000 sub itself -> Y=0, flags 0.
  - Denormal A=0x00010000 div 0xFF010000 -> Y=0x80000000.
- Control:
  - Reset pulse low mid-BUSY -> outputs 0.
  - start with FIN=1 -> outputs unchanged.
  - genonly=0 -> outputs never update.
